keystream_packer: RTL and testbench
===================================

// Module: keystream_packer
// PURPOSE
//  Downstream of the chaotic-LFSR keystream generator. Packs its 1-bit/cycle output stream
//  into WORD_W-bit words and buffers them in a small FIFO. Presents words to the consumer
//  (cipher/XOR stage) over a valid/ready handshake. The generator cannot stall, so a full
//  FIFO drops words and flags it rather than applying backpressure.
// PARAMETERS
//  WORD_W     16  packed word width (>=2)
//  FIFO_DEPTH 4   word FIFO depth, power of 2, >=2
//  REP_LIMIT  32  repetition-count health threshold, in consecutive identical bits (>=2)
// PORTS
//  clk         in   1                  clock
//  rst         in   1                  reset, asynchronous, active-high
//  enable      in   1                  packing enable
//  bit_in      in   1                  keystream bit from generator
//  bit_valid   in   1                  bit_in qualifier (low during generator pipeline warm-up)
//  word_out    out  WORD_W             head-of-FIFO word
//  word_valid  out  1                  FIFO non-empty
//  word_ready  in   1                  consumer accepts word_out this cycle
//  fifo_level  out  $clog2(FIFO_DEPTH)+1  words held
//  overflow    out  1                  sticky: a completed word was dropped
//  health_fail out  1                  sticky: repetition test tripped
// BEHAVIOUR
//  Reset: all outputs 0, bit counter 0, state IDLE, FIFO empty.
//  FSM IDLE -> COLLECT when enable=1. COLLECT -> IDLE when enable=0: partial word discarded,
//  counter cleared. Any state -> HALT on health trip; HALT exits only by rst.
//  Capture: a bit is sampled when state=COLLECT & bit_valid. Bits are MSB-first: the first
//  bit sampled lands in word bit WORD_W-1.
//  Bit counter runs 0..WORD_W-1 and wraps to 0 on the edge that samples bit WORD_W-1.
//  That same edge pushes {shreg[WORD_W-2:0], bit_in} into the FIFO.
//  Latency: word_valid rises 1 cycle after the last bit is sampled.
//  Output: first-word-fall-through. A pop occurs when word_valid & word_ready.
//  word_out is held stable while word_valid=1 & word_ready=0.
//  Full FIFO, push with no pop: word dropped, overflow<=1, assembly of the next word continues.
//  Full FIFO, push and pop in the same cycle: both succeed, level stays FIFO_DEPTH,
//  overflow unchanged.
//  Empty FIFO: no pop is possible. A push makes word_valid=1 on the next cycle.
//  Pointers wrap modulo FIFO_DEPTH. The level counter never exceeds FIFO_DEPTH.
//  bit_valid=0 mid-word: counter and shreg hold; bits are not required to be contiguous.
//  Reset mid-word or mid-handshake: everything clears immediately; stored words are lost.
// CONFIGURATION
//  KEYSTREAM_HEALTH_TEST_EN defined:
//   - A run counter counts consecutive identical sampled bits.
//   - When the run reaches REP_LIMIT: health_fail<=1, FSM->HALT.
//   - In HALT, pushes stop; words already in the FIFO still drain.
//  KEYSTREAM_HEALTH_TEST_EN undefined: health_fail tied 0, no run counter, HALT unreachable.
// STRUCTURE
//  Package clfsr_pkg holds:
//   - WORD_W / FIFO_DEPTH defaults
//   - state enum {IDLE, COLLECT, HALT}
//   - localparam LVL_W = $clog2(FIFO_DEPTH)+1
//  Sub-module ks_sync_fifo: single-clock FWFT FIFO with push/pop/full/empty/level.
//  The packer holds the FSM, shreg, bit counter and health logic.
// TESTING
//  1. enable=1, bit_valid=1, bits 1,0 x8, ready=1 -> word_out=16'hAAAA, word_valid=1 exactly
//     one cycle after the 16th bit, then popped; level back to 0.
//  2. ready=0, 5 words of 16'h1234 pushed -> level=4, overflow=1 after 5th, word_out=16'h1234;
//     ready=1 -> 4 pops then word_valid=0.
//  3. FIFO full (level=4), ready=1 on the cycle a new word completes -> level stays 4,
//     overflow stays 0.
//  4. 7 bits sampled, enable=0 for 1 cycle, re-enable, 16 bits of 16'hF00F
//     -> exactly one word 16'hF00F; the 7 bits never appear.
//  5. bit_valid toggling 1,0 every cycle with the 16'hC3A5 pattern -> word 16'hC3A5 after
//     32 cycles.
//  6. KEYSTREAM_HEALTH_TEST_EN defined: 32 zeros -> health_fail=1 on the 32nd-bit edge, the
//     2nd 16'h0000 word not pushed. Undefined: two 16'h0000 words, health_fail=0.
//     rst pulse afterwards -> all outputs 0.

Source files
------------

// File: rtl/keystream_packer_pkg.sv
// rtl/keystream_packer_pkg.sv - shared defaults and FSM state type for the keystream packer
package clfsr_pkg;
    localparam int WORD_W_DEF     = 16;
    localparam int FIFO_DEPTH_DEF = 4;
    localparam int REP_LIMIT_DEF  = 32;
    localparam int LVL_W          = $clog2(FIFO_DEPTH_DEF) + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        HALT    = 2'd2
    } state_t;
endpackage

// File: rtl/keystream_packer_if.sv
// rtl/keystream_packer_if.sv - generator-side bit stream and consumer-side word handshake
interface keystream_packer_if #(
    parameter int WORD_W     = clfsr_pkg::WORD_W_DEF,
    parameter int FIFO_DEPTH = clfsr_pkg::FIFO_DEPTH_DEF
);
    localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                enable;
    logic                bit_in;
    logic                bit_valid;
    logic [WORD_W-1:0]   word_out;
    logic                word_valid;
    logic                word_ready;
    logic [LEVEL_W-1:0]  fifo_level;
    logic                overflow;
    logic                health_fail;

    modport master (
        input  enable, bit_in, bit_valid, word_ready,
        output word_out, word_valid, fifo_level, overflow, health_fail
    );

    modport slave (
        output enable, bit_in, bit_valid, word_ready,
        input  word_out, word_valid, fifo_level, overflow, health_fail
    );
endinterface

// File: rtl/keystream_packer_fifo.sv
// rtl/keystream_packer_fifo.sv - single-clock first-word-fall-through word FIFO
module ks_sync_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == (PTR_W+1)'(DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      level <= level + 1'b1;
            else if (!do_push && do_pop) level <= level - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = empty ? '0 : mem[rd_ptr];
endmodule

// File: rtl/keystream_packer.sv
// rtl/keystream_packer.sv - packs the keystream bit stream into words; KEYSTREAM_HEALTH_TEST_EN adds the repetition test
module keystream_packer
    import clfsr_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
    parameter int REP_LIMIT  = REP_LIMIT_DEF
) (
    input  logic                clk,
    input  logic                rst,
    keystream_packer_if.master  bus
);
    localparam int CNT_W = $clog2(WORD_W);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  bit_cnt;
    logic [WORD_W-2:0] shreg;
    logic [WORD_W-1:0] word_next;
    logic              sample, last_bit, trip, push, pop;
    logic              fifo_full, fifo_empty, overflow_q;

    assign sample    = (state_q == COLLECT) && bus.enable && bus.bit_valid;
    assign last_bit  = (bit_cnt == CNT_W'(WORD_W - 1));
    assign word_next = {shreg, bus.bit_in};
    assign push      = sample && last_bit && !trip;
    assign pop       = bus.word_valid && bus.word_ready;

`ifdef KEYSTREAM_HEALTH_TEST_EN
    localparam int RUN_W = $clog2(REP_LIMIT + 1);

    logic [RUN_W-1:0] run_cnt, run_next;
    logic             prev_bit, health_q;

    assign run_next = (run_cnt != '0 && bus.bit_in == prev_bit) ? run_cnt + 1'b1 : RUN_W'(1);
    // The bit that completes the run is the trip point; it is never pushed.
    assign trip     = sample && (run_next == RUN_W'(REP_LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt  <= '0;
            prev_bit <= 1'b0;
            health_q <= 1'b0;
        end else begin
            if (sample) begin
                run_cnt  <= run_next;
                prev_bit <= bus.bit_in;
            end
            if (trip) health_q <= 1'b1;
        end
    end

    assign bus.health_fail = health_q;
`else
    assign trip            = 1'b0;
    assign bus.health_fail = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.enable)  state_d = COLLECT;
            COLLECT: if (!bus.enable) state_d = IDLE;
            HALT:    state_d = HALT;
            default: state_d = IDLE;
        endcase
        if (trip) state_d = HALT;
    end

    // Outside an enabled COLLECT cycle the partial word is abandoned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bit_cnt <= '0;
            shreg   <= '0;
        end else if (state_q != COLLECT || !bus.enable) begin
            bit_cnt <= '0;
        end else if (sample) begin
            shreg   <= word_next[WORD_W-2:0];
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                           overflow_q <= 1'b0;
        else if (push && fifo_full && !pop) overflow_q <= 1'b1;
    end

    ks_sync_fifo #(
        .W     (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (word_next),
        .pop       (pop),
        .pop_data  (bus.word_out),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (bus.fifo_level)
    );

    assign bus.word_valid = ~fifo_empty;
    assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_keystream_packer.sv
// tb/tb_keystream_packer.sv - directed and randomized checks of keystream_packer against a queue model
module tb_keystream_packer;
    localparam int W   = 16;
    localparam int D   = 4;
    localparam int LIM = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_fail = 0;

    keystream_packer_if #(.WORD_W(W), .FIFO_DEPTH(D)) bus ();
    keystream_packer #(.WORD_W(W), .FIFO_DEPTH(D), .REP_LIMIT(LIM)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    // Reference model: collecting follows last cycle's enable, words are a queue.
    bit          m_part[$];
    logic [W-1:0] m_q[$];
    bit          m_collect, m_halt, m_ovf, m_hf, m_prev;
    int          m_run;

    function automatic void model_clear();
        m_part.delete(); m_q.delete();
        m_collect = 0; m_halt = 0; m_ovf = 0; m_hf = 0; m_prev = 0; m_run = 0;
    endfunction

    task automatic tick(input bit en, input bit bv, input bit b, input bit rdy);
        bit popped, have_word;
        int pre;
        logic [W-1:0] w;
        bus.enable = en; bus.bit_valid = bv; bus.bit_in = b; bus.word_ready = rdy;
        @(posedge clk);
        have_word = 0; w = '0;
        pre = m_q.size();
        popped = (pre != 0) && rdy;
        if (m_collect && en && bv && !m_halt) begin
            m_run = (m_run != 0 && b == m_prev) ? m_run + 1 : 1;
            m_prev = b;
`ifdef KEYSTREAM_HEALTH_TEST_EN
            if (m_run == LIM) begin m_halt = 1; m_hf = 1; m_collect = 0; end
`endif
            if (!m_halt) begin
                m_part.push_back(b);
                if (m_part.size() == W) begin
                    foreach (m_part[i]) w = {w[W-2:0], m_part[i]};
                    m_part.delete();
                    have_word = 1;
                end
            end
        end
        if (!m_halt) begin
            if (!en) m_part.delete();
            m_collect = en;
        end
        if (popped) void'(m_q.pop_front());
        if (have_word) begin
            if (pre == D && !popped) m_ovf = 1;
            else m_q.push_back(w);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.enable = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.word_ready = 0;
        repeat (2) @(negedge clk);
        model_clear();
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_word(input logic [W-1:0] pat, input bit rdy);
        for (int k = W - 1; k >= 0; k--) tick(1, 1, pat[k], rdy);
    endtask

    task automatic test_reset();
        do_reset();
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.word_out !== '0)     begin n_fail++; $display("FAIL reset_word_out got %h exp 0", bus.word_out); end
        n_cmp++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL reset_word_valid got %b exp 0", bus.word_valid); end
        n_cmp++; if (bus.fifo_level !== '0)   begin n_fail++; $display("FAIL reset_level got %0d exp 0", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL reset_overflow got %b exp 0", bus.overflow); end
        n_cmp++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL reset_health got %b exp 0", bus.health_fail); end
        rst = 1'b0;
    endtask

    task automatic test_pack_aaaa();
        logic [W-1:0] pat = 16'hAAAA;
        do_reset();
        tick(1, 0, 0, 1);
        for (int k = W - 1; k >= 1; k--) tick(1, 1, pat[k], 1);
        n_cmp++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL aaaa_early_valid got %b exp 0", bus.word_valid); end
        tick(1, 1, pat[0], 1);
        n_cmp++; if (bus.word_valid !== 1'b1) begin n_fail++; $display("FAIL aaaa_valid got %b exp 1", bus.word_valid); end
        n_cmp++; if (bus.word_out !== 16'hAAAA) begin n_fail++; $display("FAIL aaaa_word got %h exp aaaa", bus.word_out); end
        tick(1, 0, 0, 1);
        n_cmp++; if (bus.fifo_level !== 3'd0) begin n_fail++; $display("FAIL aaaa_level_after_pop got %0d exp 0", bus.fifo_level); end
    endtask

    task automatic test_overflow();
        do_reset();
        tick(1, 0, 0, 0);
        for (int n = 1; n <= 5; n++) begin
            send_word(16'h1234, 0);
            if (n == 4) begin
                n_cmp++; if (bus.overflow !== 1'b0) begin n_fail++; $display("FAIL ovf_early got %b exp 0", bus.overflow); end
            end
        end
        n_cmp++; if (bus.fifo_level !== 3'd4)   begin n_fail++; $display("FAIL ovf_level got %0d exp 4", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b1)     begin n_fail++; $display("FAIL ovf_flag got %b exp 1", bus.overflow); end
        for (int n = 0; n < 4; n++) begin
            n_cmp++; if (bus.word_out !== 16'h1234) begin n_fail++; $display("FAIL ovf_drain_word%0d got %h exp 1234", n, bus.word_out); end
            tick(1, 0, 0, 1);
        end
        n_cmp++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_drained_valid got %b exp 0", bus.word_valid); end
    endtask

    task automatic test_full_push_pop();
        logic [W-1:0] words[5];
        do_reset();
        tick(1, 0, 0, 0);
        foreach (words[i]) words[i] = W'($urandom_range(1, 16'hFFFE)) ^ 16'h5A5A;
        for (int i = 0; i < 4; i++) send_word(words[i], 0);
        n_cmp++; if (bus.fifo_level !== 3'd4) begin n_fail++; $display("FAIL full_level got %0d exp 4", bus.fifo_level); end
        for (int k = W - 1; k >= 1; k--) tick(1, 1, words[4][k], 0);
        tick(1, 1, words[4][0], 1);
        n_cmp++; if (bus.fifo_level !== 3'd4) begin n_fail++; $display("FAIL pushpop_level got %0d exp 4", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0)   begin n_fail++; $display("FAIL pushpop_overflow got %b exp 0", bus.overflow); end
        n_cmp++; if (bus.word_out !== words[1]) begin n_fail++; $display("FAIL pushpop_head got %h exp %h", bus.word_out, words[1]); end
        for (int i = 2; i <= 5; i++) begin
            tick(1, 0, 0, 1);
            if (i <= 4) begin
                n_cmp++; if (bus.word_out !== words[i]) begin n_fail++; $display("FAIL pushpop_order%0d got %h exp %h", i, bus.word_out, words[i]); end
            end
        end
    endtask

    task automatic test_abort();
        do_reset();
        tick(1, 0, 0, 0);
        for (int k = 0; k < 7; k++) tick(1, 1, 1'($urandom), 0);
        tick(0, 1, 1'($urandom), 0);
        tick(1, 0, 0, 0);
        send_word(16'hF00F, 0);
        tick(1, 0, 0, 0);
        n_cmp++; if (bus.fifo_level !== 3'd1)  begin n_fail++; $display("FAIL abort_level got %0d exp 1", bus.fifo_level); end
        n_cmp++; if (bus.word_out !== 16'hF00F) begin n_fail++; $display("FAIL abort_word got %h exp f00f", bus.word_out); end
        tick(1, 0, 0, 1);
        n_cmp++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL abort_extra_word got valid %b exp 0", bus.word_valid); end
    endtask

    task automatic test_gapped_bits();
        logic [W-1:0] pat = 16'hC3A5;
        do_reset();
        tick(1, 0, 0, 0);
        for (int i = 0; i < 2 * W; i++) begin
            if (i % 2 == 0) tick(1, 1, pat[W - 1 - i / 2], 0);
            else            tick(1, 0, 1'($urandom), 0);
            if (i == 2 * W - 3) begin
                n_cmp++; if (bus.word_valid !== 1'b0) begin n_fail++; $display("FAIL gap_early_valid got %b exp 0", bus.word_valid); end
            end
        end
        n_cmp++; if (bus.fifo_level !== 3'd1)  begin n_fail++; $display("FAIL gap_level got %0d exp 1", bus.fifo_level); end
        n_cmp++; if (bus.word_out !== 16'hC3A5) begin n_fail++; $display("FAIL gap_word got %h exp c3a5", bus.word_out); end
    endtask

    task automatic test_random();
        bit en, bv, b, rdy;
        do_reset();
        for (int c = 0; c < 1500; c++) begin
            en  = ($urandom_range(0, 40) != 0);
            bv  = ($urandom_range(0, 3) != 0);
            b   = 1'($urandom);
            rdy = ($urandom_range(0, 2) == 0);
            tick(en, bv, b, rdy);
            n_cmp++; if (bus.word_valid !== (m_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid cyc %0d got %b exp %b", c, bus.word_valid, m_q.size() != 0); end
            n_cmp++; if (bus.fifo_level !== 3'(m_q.size()))     begin n_fail++; $display("FAIL rnd_level cyc %0d got %0d exp %0d", c, bus.fifo_level, m_q.size()); end
            n_cmp++; if (bus.overflow !== m_ovf)                begin n_fail++; $display("FAIL rnd_overflow cyc %0d got %b exp %b", c, bus.overflow, m_ovf); end
            n_cmp++; if (bus.health_fail !== m_hf)              begin n_fail++; $display("FAIL rnd_health cyc %0d got %b exp %b", c, bus.health_fail, m_hf); end
            if (m_q.size() != 0) begin
                n_cmp++; if (bus.word_out !== m_q[0]) begin n_fail++; $display("FAIL rnd_word cyc %0d got %h exp %h", c, bus.word_out, m_q[0]); end
            end
        end
    endtask

    task automatic test_health();
        do_reset();
        tick(1, 0, 0, 0);
        send_word(16'h0000, 0);
        n_cmp++; if (bus.fifo_level !== 3'd1) begin n_fail++; $display("FAIL health_first_word level %0d exp 1", bus.fifo_level); end
        send_word(16'h0000, 0);
`ifdef KEYSTREAM_HEALTH_TEST_EN
        n_cmp++; if (bus.health_fail !== 1'b1) begin n_fail++; $display("FAIL health_trip got %b exp 1", bus.health_fail); end
        n_cmp++; if (bus.fifo_level !== 3'd1)  begin n_fail++; $display("FAIL health_no_push level %0d exp 1", bus.fifo_level); end
        for (int k = 0; k < W; k++) tick(1, 1, 1'($urandom), 0);
        n_cmp++; if (bus.fifo_level !== 3'd1)  begin n_fail++; $display("FAIL health_halted level %0d exp 1", bus.fifo_level); end
        tick(1, 0, 0, 1);
        n_cmp++; if (bus.word_valid !== 1'b0)  begin n_fail++; $display("FAIL health_drain valid %b exp 0", bus.word_valid); end
`else
        n_cmp++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL health_disabled got %b exp 0", bus.health_fail); end
        n_cmp++; if (bus.fifo_level !== 3'd2)  begin n_fail++; $display("FAIL health_two_words level %0d exp 2", bus.fifo_level); end
`endif
        rst = 1'b1;
        #1;
        n_cmp++; if (bus.word_out !== '0)      begin n_fail++; $display("FAIL rst_pulse_word got %h exp 0", bus.word_out); end
        n_cmp++; if (bus.word_valid !== 1'b0)  begin n_fail++; $display("FAIL rst_pulse_valid got %b exp 0", bus.word_valid); end
        n_cmp++; if (bus.fifo_level !== '0)    begin n_fail++; $display("FAIL rst_pulse_level got %0d exp 0", bus.fifo_level); end
        n_cmp++; if (bus.overflow !== 1'b0)    begin n_fail++; $display("FAIL rst_pulse_overflow got %b exp 0", bus.overflow); end
        n_cmp++; if (bus.health_fail !== 1'b0) begin n_fail++; $display("FAIL rst_pulse_health got %b exp 0", bus.health_fail); end
        do_reset();
    endtask

    initial begin
        bus.enable = 0; bus.bit_valid = 0; bus.bit_in = 0; bus.word_ready = 0;
        model_clear();
        @(negedge clk);
        test_reset();
        test_pack_aaaa();
        test_overflow();
        test_full_push_pop();
        test_abort();
        test_gapped_bits();
        test_random();
        test_health();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
